relay_mem_arbiter: RTL and testbench
====================================

Name: relay_mem_arbiter

Overview:
Owns the relay-state byte array that drives the SPI slave's `memory` input bus, and arbitrates byte writes into it from NUM_REQ requesters (e.g. SPI write decoder, local host, self-test). Grants one write at a time using round-robin. After every write it holds off further writes for SETTLE_CYCLES so that relay coils are never switched back-to-back.

Parameters:
WIDTH, 16, total width of the memory bus in bits; must be a multiple of 8; byte n occupies bits [8n+7:8n]
NUM_REQ, 2, number of write requesters (1..8)
SETTLE_CYCLES, 4, idle cycles enforced after each accepted write (0 allowed)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  reset is synchronous and active-high
req_valid  input  NUM_REQ  per-requester write request
req_ready  output  NUM_REQ  one-hot grant/accept pulse
req_addr  input  NUM_REQ*16  byte address per requester; requester k uses [16k+15:16k]
req_data  input  NUM_REQ*8  write byte per requester; requester k uses [8k+7:8k]
memory  output  WIDTH  registered byte array, feeds the SPI slave
busy  output  1  high in WRITE and SETTLE
err_addr  output  1  one-cycle pulse when a granted address is >= WIDTH/8

Behaviour:
- Reset values: memory=0, req_ready=0, busy=0, err_addr=0, state=IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority), settle counter=0.
- Reset mid-operation aborts the transfer, clears memory and issues no ready pulse.
- State IDLE:
  - If req_valid is nonzero, pick the first set bit searching last_grant+1, +2, ... with modulo NUM_REQ wrap.
  - Assert req_ready[g] for exactly one cycle, in the same cycle the grant is taken (transfer = valid&&ready).
  - Latch addr/data of requester g, update last_grant=g, go to WRITE.
- State WRITE (1 cycle):
  - If addr < WIDTH/8, write memory[addr*8 +: 8]=data; other bytes hold.
  - Otherwise leave memory unchanged and pulse err_addr.
  - If SETTLE_CYCLES==0, go to IDLE; else load counter=SETTLE_CYCLES-1 and go to SETTLE.
- State SETTLE: decrement the counter each cycle; when the counter is 0, go to IDLE.
- Latency and throughput:
  - A new memory value is visible 2 cycles after the valid cycle in which ready was given.
  - Minimum spacing between grants is 2+SETTLE_CYCLES cycles.
- Requesters must hold valid, addr and data stable until they see ready.
  - If valid drops before a grant, no write occurs and no error is flagged.
  - Valid asserted during WRITE or SETTLE is ignored until IDLE.
- Only one grant can be issued per cycle. Requests raised simultaneously are served in round-robin order; no requester waits more than NUM_REQ grants.
- busy=1 exactly while state is WRITE or SETTLE.
- memory changes only in the WRITE cycle. The SPI slave samples it asynchronously to this block; byte atomicity is guaranteed because a single write touches only one byte.
- Address compare uses the full 16 bits; there is no wrap or truncation.

Optional Feature:
RELAY_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, lowest index wins; last_grant is not used for selection.
- Undefined: round-robin as specified above.
- All other timing is identical in both builds.

Decomposition:
- Package relay_pkg:
  - ADDR_W=16, BYTE_W=8
  - state enum {IDLE, WRITE, SETTLE}
  - function for next round-robin index.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, last_grant, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
  - Swapped for priority-encode logic under RELAY_ARB_FIXED_PRIO_EN.

Test Plan:
1. Reset, then req0 addr=0x0001 data=0x03 → req_ready[0] pulses once, memory=16'h0300 two cycles later, busy high for 1+4 cycles.
2. req0 and req1 raised in the same cycle (addr 0/data 0xAA, addr 1/data 0x55) → req0 granted first, req1 granted exactly 6 cycles later, final memory=16'h55AA.
3. Hold req1 continuously while req0 re-requests → grants alternate 0,1,0,1; with RELAY_ARB_FIXED_PRIO_EN, req0 wins every grant.
4. req0 addr=0x0002 data=0xFF (WIDTH=16) → err_addr pulses one cycle, memory unchanged, ready still pulses, settle is still enforced.
5. Assert reset during SETTLE after writing 0x80 to addr 1 → memory=0 on the next cycle, state IDLE, the next request is granted immediately.
6. SETTLE_CYCLES=0: back-to-back req0 writes to addr 0 with 0x01 then 0x02 → grants 2 cycles apart, memory[7:0] sequence 0x01, 0x02.

Source files
------------

// File: rtl/relay_pkg.sv
// Shared types and helpers for the relay memory arbiter: widths, FSM states
// and the round-robin search order.
package relay_pkg;

    localparam int ADDR_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Candidate index visited at search position 'step' after the last winner.
    function automatic int unsigned rr_next(input int unsigned last,
                                            input int unsigned step,
                                            input int unsigned n);
        return (last + 1 + step) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-of-N grant selector for the relay memory arbiter.
// Round-robin by default; RELAY_ARB_FIXED_PRIO_EN selects lowest-index-wins.
module rr_arbiter
    import relay_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

`ifdef RELAY_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (enable && req[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end
`else
    always_comb begin
        int unsigned idx;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = rr_next(int'(last_grant), i, NUM_REQ);
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end
`endif

endmodule

// File: rtl/relay_mem_arbiter.sv
// Relay-state byte array with arbitrated single-byte writes and a settle
// hold-off after every write. Optional macro: RELAY_ARB_FIXED_PRIO_EN.
module relay_mem_arbiter
    import relay_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int NUM_REQ       = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*BYTE_W-1:0]  req_data,
    output logic [WIDTH-1:0]           memory,
    output logic                       busy,
    output logic                       err_addr
);

    localparam int NUM_BYTES = WIDTH / BYTE_W;
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [IDX_W-1:0]    last_grant_reg, last_grant_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [BYTE_W-1:0]   data_reg, data_next;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [BYTE_W-1:0]   data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                arb_enable;
    logic                write_en;
    logic [NUM_REQ-1:0]  ready_c;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi] = req_addr[ADDR_W*gi +: ADDR_W];
            assign data_arr[gi] = req_data[BYTE_W*gi +: BYTE_W];
        end
    endgenerate

    // Reset gates the arbiter so a request held across reset never sees ready.
    assign arb_enable = (state_reg == IDLE) && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .enable     (arb_enable),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            addr_reg       <= '0;
            data_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            last_grant_reg <= last_grant_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        last_grant_next = last_grant_reg;
        addr_next       = addr_reg;
        data_next       = data_reg;
        ready_c         = '0;
        busy            = 1'b0;
        err_addr        = 1'b0;
        write_en        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|grant) begin
                    ready_c         = grant;
                    addr_next       = addr_arr[grant_idx];
                    data_next       = data_arr[grant_idx];
                    last_grant_next = grant_idx;
                    state_next      = WRITE;
                end
            end
            WRITE: begin
                busy = 1'b1;
                // Full 16-bit compare: out-of-range addresses never alias.
                if (addr_reg < ADDR_W'(NUM_BYTES)) begin
                    write_en = 1'b1;
                end else begin
                    err_addr = 1'b1;
                end
                if (SETTLE_CYCLES == 0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req_ready = ready_c;

    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
            logic [BYTE_W-1:0] byte_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    byte_reg <= '0;
                end else if (write_en && addr_reg == ADDR_W'(gi)) begin
                    byte_reg <= data_reg;
                end
            end
            assign memory[BYTE_W*gi +: BYTE_W] = byte_reg;
        end
    endgenerate

endmodule

// File: tb/tb_relay_mem_arbiter.sv
// Self-checking bench for relay_mem_arbiter: default build (SETTLE_CYCLES=4)
// plus a SETTLE_CYCLES=0 instance for back-to-back grants.
module tb_relay_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_addr;
    logic [15:0] req_data;
    logic [15:0] memory;
    logic        busy;
    logic        err_addr;

    logic        v0;
    logic        ready0;
    logic [15:0] a0;
    logic [7:0]  d0;
    logic [15:0] mem0;
    logic        busy0;
    logic        err0;

    typedef struct {
        logic [1:0]  ready;
        logic [15:0] mem;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem_model;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    relay_mem_arbiter #(.WIDTH(16), .NUM_REQ(2), .SETTLE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .memory    (memory),
        .busy      (busy),
        .err_addr  (err_addr)
    );

    relay_mem_arbiter #(.WIDTH(16), .NUM_REQ(1), .SETTLE_CYCLES(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (v0),
        .req_ready (ready0),
        .req_addr  (a0),
        .req_data  (d0),
        .memory    (mem0),
        .busy      (busy0),
        .err_addr  (err0)
    );

    function automatic void push_exp(input int g, input logic [15:0] addr, input logic [7:0] data);
        exp_t e;
        e.ready = 2'(1 << g);
        e.err   = (addr >= 16'd2);
        if (!e.err) mem_model[int'(addr)*8 +: 8] = data;
        e.mem = mem_model;
        sb.push_back(e);
    endfunction

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        v0        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_model = '0;
        sb.delete();
    endtask

    // Ends at the negedge of the cycle where ready is seen (ok=1), else ok=0.
    task automatic wait_ready(input int max, output int ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                ok = 1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 2'b01;
        req_addr  = 32'h0;
        req_data  = 16'h0077;
        v0 = 1'b0; a0 = '0; d0 = '0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_ready got=%b exp=00", req_ready); else n_pass++;
        n_checks++; if (memory !== 16'h0000) $display("FAIL reset_memory got=%h exp=0000", memory); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (err_addr !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_addr); else n_pass++;
        n_checks++; if (mem0 !== 16'h0000) $display("FAIL reset_mem0 got=%h exp=0000", mem0); else n_pass++;
        @(posedge clk); #1;
        req_valid = '0;
        reset     = 1'b0;
        mem_model = '0;
        sb.delete();
    endtask

    task automatic test_single_write();
        exp_t e;
        int   ok;
        int   busy_cnt;
        apply_reset();
        req_addr[15:0] = 16'h0001;
        req_data[7:0]  = 8'h03;
        req_valid      = 2'b01;
        push_exp(0, 16'h0001, 8'h03);
        wait_ready(4, ok);
        n_checks++;
        if (!ok) begin
            $display("FAIL single_grant got=timeout exp=ready");
            return;
        end
        e = sb.pop_front();
        if (req_ready !== e.ready) $display("FAIL single_ready got=%b exp=%b", req_ready, e.ready); else n_pass++;
        $display("txn single: grant=%b addr=0001 data=03", req_ready);
        busy_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) req_valid = '0;
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (k == 1) begin
                n_checks++; if (err_addr !== e.err) $display("FAIL single_err got=%b exp=%b", err_addr, e.err); else n_pass++;
                n_checks++; if (memory !== 16'h0000) $display("FAIL single_mem_early got=%h exp=0000", memory); else n_pass++;
            end
            if (k == 2) begin
                n_checks++; if (memory !== e.mem) $display("FAIL single_mem got=%h exp=%h", memory, e.mem); else n_pass++;
            end
        end
        n_checks++; if (busy_cnt !== 5) $display("FAIL single_busy_len got=%0d exp=5", busy_cnt); else n_pass++;
    endtask

    task automatic test_simultaneous();
        exp_t e;
        int   ok;
        int   g0;
        apply_reset();
        req_addr  = {16'h0001, 16'h0000};
        req_data  = {8'h55, 8'hAA};
        req_valid = 2'b11;
        push_exp(0, 16'h0000, 8'hAA);
        push_exp(1, 16'h0001, 8'h55);
        wait_ready(4, ok);
        n_checks++;
        if (!ok) begin
            $display("FAIL simul_first got=timeout exp=ready");
            return;
        end
        e  = sb.pop_front();
        g0 = cyc;
        if (req_ready !== e.ready) $display("FAIL simul_first got=%b exp=%b", req_ready, e.ready); else n_pass++;
        $display("txn simul: grant=%b cycle=%0d", req_ready, g0);
        @(posedge clk); #1;
        if (req_ready[0] === 1'b1) req_valid[0] = 1'b0;
        if (req_ready[1] === 1'b1) req_valid[1] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (memory !== e.mem) $display("FAIL simul_mem1 got=%h exp=%h", memory, e.mem); else n_pass++;
        @(posedge clk); #1;
        wait_ready(8, ok);
        n_checks++;
        if (!ok) begin
            $display("FAIL simul_second got=timeout exp=ready");
            req_valid = '0;
            return;
        end
        e = sb.pop_front();
        if (req_ready !== e.ready) $display("FAIL simul_second got=%b exp=%b", req_ready, e.ready); else n_pass++;
        $display("txn simul: grant=%b cycle=%0d", req_ready, cyc);
        n_checks++; if (cyc - g0 !== 6) $display("FAIL simul_spacing got=%0d exp=6", cyc - g0); else n_pass++;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (memory !== e.mem) $display("FAIL simul_mem2 got=%h exp=%h", memory, e.mem); else n_pass++;
    endtask

    task automatic test_rr_alternate();
        exp_t       e;
        int         ok;
        int         gprev;
        int         c0;
        int         c1;
        int         g;
        logic [1:0] rdy;
        apply_reset();
        req_addr  = {16'h0001, 16'h0000};
        req_data  = {8'h20, 8'h10};
        req_valid = 2'b11;
        c0 = 0; c1 = 0;
        for (int n = 0; n < 4; n++) begin
`ifdef RELAY_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = n % 2;
`endif
            if (g == 0) begin push_exp(0, 16'h0000, 8'(8'h10 + c0)); c0++; end
            else        begin push_exp(1, 16'h0001, 8'(8'h20 + c1)); c1++; end
        end
        gprev = 0;
        for (int n = 0; n < 4; n++) begin
            wait_ready(8, ok);
            n_checks++;
            if (!ok) begin
                $display("FAIL rr_grant%0d got=timeout exp=ready", n);
                break;
            end
            e   = sb.pop_front();
            rdy = req_ready;
            if (rdy !== e.ready) $display("FAIL rr_grant%0d got=%b exp=%b", n, rdy, e.ready); else n_pass++;
            $display("txn rr: n=%0d grant=%b cycle=%0d", n, rdy, cyc);
            if (n > 0) begin
                n_checks++; if (cyc - gprev !== 6) $display("FAIL rr_spacing%0d got=%0d exp=6", n, cyc - gprev); else n_pass++;
            end
            gprev = cyc;
            @(posedge clk); #1;
            if (rdy[0]) req_data[7:0]  = req_data[7:0] + 8'd1;
            if (rdy[1]) req_data[15:8] = req_data[15:8] + 8'd1;
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++; if (memory !== e.mem) $display("FAIL rr_mem%0d got=%h exp=%h", n, memory, e.mem); else n_pass++;
            @(posedge clk); #1;
        end
        req_valid = '0;
    endtask

    task automatic test_bad_addr();
        exp_t e;
        int   ok;
        int   g0;
        apply_reset();
        req_addr[15:0] = 16'h0002;
        req_data[7:0]  = 8'hFF;
        req_valid      = 2'b01;
        push_exp(0, 16'h0002, 8'hFF);
        wait_ready(4, ok);
        n_checks++;
        if (!ok) begin
            $display("FAIL bad_grant got=timeout exp=ready");
            req_valid = '0;
            return;
        end
        e  = sb.pop_front();
        g0 = cyc;
        if (req_ready !== e.ready) $display("FAIL bad_ready got=%b exp=%b", req_ready, e.ready); else n_pass++;
        $display("txn bad: grant=%b addr=0002 data=FF", req_ready);
        @(posedge clk); #1;
        req_addr[15:0] = 16'h0000;
        req_data[7:0]  = 8'h11;
        push_exp(0, 16'h0000, 8'h11);
        @(negedge clk);
        n_checks++; if (err_addr !== e.err) $display("FAIL bad_err got=%b exp=%b", err_addr, e.err); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL bad_busy got=%b exp=1", busy); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (err_addr !== 1'b0) $display("FAIL bad_err_pulse got=%b exp=0", err_addr); else n_pass++;
        n_checks++; if (memory !== e.mem) $display("FAIL bad_mem got=%h exp=%h", memory, e.mem); else n_pass++;
        @(posedge clk); #1;
        wait_ready(8, ok);
        n_checks++;
        if (!ok) begin
            $display("FAIL bad_next got=timeout exp=ready");
            req_valid = '0;
            return;
        end
        e = sb.pop_front();
        if (cyc - g0 !== 6) $display("FAIL bad_settle got=%0d exp=6", cyc - g0); else n_pass++;
        $display("txn bad: grant=%b addr=0000 data=11 cycle=%0d", req_ready, cyc);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (memory !== e.mem) $display("FAIL bad_mem2 got=%h exp=%h", memory, e.mem); else n_pass++;
    endtask

    task automatic test_reset_in_settle();
        exp_t e;
        int   ok;
        apply_reset();
        req_addr[15:0] = 16'h0001;
        req_data[7:0]  = 8'h80;
        req_valid      = 2'b01;
        push_exp(0, 16'h0001, 8'h80);
        wait_ready(4, ok);
        n_checks++;
        if (!ok) begin
            $display("FAIL rst_grant got=timeout exp=ready");
            req_valid = '0;
            return;
        end
        e = sb.pop_front();
        n_pass++;
        $display("txn rst: grant=%b addr=0001 data=80", req_ready);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (memory !== e.mem) $display("FAIL rst_mem_pre got=%h exp=%h", memory, e.mem); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mem_model = '0;
        sb.delete();
        req_addr[15:0] = 16'h0000;
        req_data[7:0]  = 8'h42;
        req_valid      = 2'b01;
        push_exp(0, 16'h0000, 8'h42);
        @(negedge clk);
        n_checks++; if (memory !== 16'h0000) $display("FAIL rst_mem_clear got=%h exp=0000", memory); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
        e = sb.pop_front();
        n_checks++; if (req_ready !== e.ready) $display("FAIL rst_regrant got=%b exp=%b", req_ready, e.ready); else n_pass++;
        $display("txn rst: grant=%b addr=0000 data=42", req_ready);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (memory !== e.mem) $display("FAIL rst_mem_post got=%h exp=%h", memory, e.mem); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] q0[$];
        logic [7:0] exp_b;
        int         ok;
        ok = 0;
        a0 = 16'h0000;
        d0 = 8'h01;
        v0 = 1'b1;
        q0.push_back(8'h01);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ready0 === 1'b1) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!ok) begin
            $display("FAIL b2b_grant1 got=timeout exp=ready");
            v0 = 1'b0;
            return;
        end
        n_pass++;
        $display("txn b2b: grant=1 data=01 cycle=%0d", cyc);
        @(posedge clk); #1;
        d0 = 8'h02;
        q0.push_back(8'h02);
        @(negedge clk);
        n_checks++; if (busy0 !== 1'b1) $display("FAIL b2b_busy got=%b exp=1", busy0); else n_pass++;
        n_checks++; if (ready0 !== 1'b0) $display("FAIL b2b_ready_write got=%b exp=0", ready0); else n_pass++;
        n_checks++; if (err0 !== 1'b0) $display("FAIL b2b_err got=%b exp=0", err0); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (ready0 !== 1'b1) $display("FAIL b2b_grant2 got=%b exp=1", ready0); else n_pass++;
        $display("txn b2b: grant=%b data=02 cycle=%0d", ready0, cyc);
        exp_b = q0.pop_front();
        n_checks++; if (mem0[7:0] !== exp_b) $display("FAIL b2b_mem1 got=%h exp=%h", mem0[7:0], exp_b); else n_pass++;
        @(posedge clk); #1;
        v0 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        exp_b = q0.pop_front();
        n_checks++; if (mem0[7:0] !== exp_b) $display("FAIL b2b_mem2 got=%h exp=%h", mem0[7:0], exp_b); else n_pass++;
        n_checks++; if (busy0 !== 1'b0) $display("FAIL b2b_idle got=%b exp=0", busy0); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_write();
        test_simultaneous();
        test_rr_alternate();
        test_bad_addr();
        test_reset_in_settle();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
